fm_weight_reader: RTL

Parameter-fetch engine between the external flash memory and the digit-recognizer datapath. On a start request it computes the flash base address for one neuron (hidden or output layer), reads that neuron's 16-bit bias and its packed weight words over the flash address/data interface, and unpacks each weight word into four 4-bit weights. The weights are streamed to the MAC under a valid/ready handshake. It is the reading end of the flash: it drives `fm_address` and samples `fm_data`.

---
 rtl/fm_weight_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fm_weight_reader.sv
// Flash parameter fetch: reads one neuron's bias and packed weight words,
// streams 4-bit weights (w0 first) to the MAC under valid/ready.
// Ports: clk, n_rst | start, layer, neuron | fm_address, fm_data |
//        bias, bias_valid | weight, weight_valid, weight_ready, last_weight |
//        busy, done, error
module fm_weight_reader #(
  parameter int NUM_HIDDEN   = 8,
  parameter int HIDDEN_WORDS = 36,
  parameter int NUM_OUTPUT   = 10,
  parameter int OUTPUT_WORDS = 2,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        layer,
  input  logic [3:0]  neuron,
  output logic [15:0] fm_address,
  input  logic [15:0] fm_data,
  output logic [15:0] bias,
  output logic        bias_valid,
  output logic [3:0]  weight,
  output logic        weight_valid,
  input  logic        weight_ready,
  output logic        last_weight,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] L_HSTRIDE = 16'(HIDDEN_WORDS + 1);
  localparam logic [15:0] L_OSTRIDE = 16'(OUTPUT_WORDS + 1);
  localparam logic [15:0] L_OBASE   =
    16'(NUM_HIDDEN * (HIDDEN_WORDS + 1));
  localparam logic [4:0]  L_NH      = 5'(NUM_HIDDEN);
  localparam logic [4:0]  L_NO      = 5'(NUM_OUTPUT);
  localparam logic [7:0]  L_HLAST   = 8'(HIDDEN_WORDS - 1);
  localparam logic [7:0]  L_OLAST   = 8'(OUTPUT_WORDS - 1);
  localparam logic [2:0]  L_WLAST   = 3'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_WAIT,
    S_WORD_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_bias;
  logic        r_bias_valid;
  logic [15:0] r_shift;
  logic [1:0]  r_nib;
  logic [7:0]  r_word;
  logic [2:0]  r_wait;
  logic        r_layer;
  logic        r_error;

  logic [15:0] w_idx;
  logic [15:0] w_base;
  logic        w_oor;
  logic        w_wait_done;
  logic        w_last_word;
  logic        w_last_nib;
  logic        w_accept;
  logic        w_go;
  logic        w_err;

  assign w_idx  = {12'd0, neuron};
  assign w_base = layer ? (L_OBASE + w_idx * L_OSTRIDE)
                        : (w_idx * L_HSTRIDE);
  assign w_oor  = layer ? ({1'b0, neuron} >= L_NO)
                        : ({1'b0, neuron} >= L_NH);

  assign w_wait_done = (r_wait == L_WLAST);
  assign w_last_word = (r_word == (r_layer ? L_OLAST : L_HLAST));
  assign w_last_nib  = (r_nib == 2'd3);
  assign w_accept    = (r_state == S_EMIT) && weight_ready;

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_oor) begin
            w_err = 1'b1;
          end else begin
            w_go   = 1'b1;
            w_next = S_BIAS_WAIT;
          end
        end
      end
      S_BIAS_WAIT: begin
        if (w_wait_done) w_next = S_WORD_WAIT;
      end
      S_WORD_WAIT: begin
        if (w_wait_done) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (w_accept && w_last_nib)
          w_next = w_last_word ? S_DONE : S_WORD_WAIT;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr       <= '0;
      r_bias       <= '0;
      r_bias_valid <= 1'b0;
      r_shift      <= '0;
      r_nib        <= '0;
      r_word       <= '0;
      r_wait       <= '0;
      r_layer      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_bias_valid <= 1'b0;
      r_error      <= w_err;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_addr  <= w_base;
            r_word  <= '0;
            r_wait  <= '0;
            r_nib   <= '0;
            r_layer <= layer;
          end
        end
        S_BIAS_WAIT: begin
          if (w_wait_done) begin
            r_bias       <= fm_data;
            r_bias_valid <= 1'b1;
            r_addr       <= r_addr + 16'd1;
            r_wait       <= '0;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_WORD_WAIT: begin
          if (w_wait_done) begin
            r_shift <= fm_data;
            r_nib   <= '0;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            r_shift <= {r_shift[11:0], 4'h0};
            r_nib   <= r_nib + 2'd1;
            // next word address only when another word follows
            if (w_last_nib && !w_last_word) begin
              r_addr <= r_addr + 16'd1;
              r_word <= r_word + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fm_address   = r_addr;
  assign bias         = r_bias;
  assign bias_valid   = r_bias_valid;
  assign weight       = r_shift[15:12];
  assign weight_valid = (r_state == S_EMIT);
  assign last_weight  = weight_valid && w_last_word && w_last_nib;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign error        = r_error;

endmodule
